// File: rtl/sm_banked_memory_pipelined.sv
// Banked scratchpad: BANKS byte-writable single-port banks with a valid-tracked read pipeline.
// Define SM_INIT_ON_RESET_EN to zero every entry of every bank after each reset.
module sm_banked_memory_pipelined #(
    parameter int BANKS           = 16,
    parameter int ENTRIES         = 1024,
    parameter int ADDR_WIDTH      = $clog2(ENTRIES),
    parameter int BYTES_PER_ENTRY = 4,
    parameter int READ_LATENCY    = 1
) (
    input  logic                                 clock_i,
    input  logic                                 reset_i,
    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic                                 is_store_i,
    input  logic [BANKS-1:0]                     enables_i,
    input  logic [BANKS*ADDR_WIDTH-1:0]          bank_offsets_i,
    input  logic [BANKS*BYTES_PER_ENTRY-1:0]     byte_mask_i,
    input  logic [BANKS*BYTES_PER_ENTRY*8-1:0]   write_data_i,
    output logic                                 read_valid_o,
    output logic [BANKS-1:0]                     read_enables_o,
    output logic [BANKS*BYTES_PER_ENTRY*8-1:0]   read_data_o,
    output logic                                 init_done_o
);
    localparam int DW = BYTES_PER_ENTRY * 8;
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(ENTRIES - 1);

    typedef enum logic {ST_INIT, ST_READY} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
    logic                    init_wr;
    logic                    accept, ld_acc, st_acc;
    logic [BANKS-1:0][DW-1:0] rd_raw;

    logic [READ_LATENCY:1]                      vld_q;
    logic [READ_LATENCY:1][BANKS-1:0]           en_q;
    logic [READ_LATENCY:1][BANKS-1:0][DW-1:0]   dat_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
`ifdef SM_INIT_ON_RESET_EN
            if (cnt_q == LAST) state_d = ST_READY;
`else
            state_d = ST_READY;
`endif
        end
    end

    always_comb begin
        req_ready_o = (state_q == ST_READY);
        init_done_o = (state_q == ST_READY);
`ifdef SM_INIT_ON_RESET_EN
        init_wr     = (state_q == ST_INIT);
`else
        init_wr     = 1'b0;
`endif
    end

    assign accept = req_valid_i & req_ready_o;
    assign ld_acc = accept & ~is_store_i;
    assign st_acc = accept & is_store_i;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [DW-1:0]              mem [ENTRIES];
        logic [ADDR_WIDTH-1:0]      waddr;
        logic [BYTES_PER_ENTRY-1:0] wbe;
        logic [DW-1:0]              wdat;

        // The init engine owns the write port while INIT is active.
        assign waddr = init_wr ? cnt_q[ADDR_WIDTH-1:0] : bank_offsets_i[b*ADDR_WIDTH +: ADDR_WIDTH];
        assign wbe   = init_wr ? '1
                     : (st_acc & enables_i[b]) ? byte_mask_i[b*BYTES_PER_ENTRY +: BYTES_PER_ENTRY]
                     : '0;
        assign wdat  = init_wr ? '0 : write_data_i[b*DW +: DW];

        always_ff @(posedge clock_i) begin
            for (int k = 0; k < BYTES_PER_ENTRY; k++)
                if (wbe[k]) mem[waddr][k*8 +: 8] <= wdat[k*8 +: 8];
        end

        assign rd_raw[b] = mem[bank_offsets_i[b*ADDR_WIDTH +: ADDR_WIDTH]];
    end

    // Stage 1 is the RAM output register; disabled lanes are zeroed at capture.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            vld_q <= '0;
            en_q  <= '0;
            dat_q <= '0;
        end else begin
            vld_q[1] <= ld_acc;
            en_q[1]  <= ld_acc ? enables_i : '0;
            for (int b = 0; b < BANKS; b++)
                dat_q[1][b] <= (ld_acc & enables_i[b]) ? rd_raw[b] : '0;
            for (int s = 2; s <= READ_LATENCY; s++) begin
                vld_q[s] <= vld_q[s-1];
                en_q[s]  <= en_q[s-1];
                dat_q[s] <= dat_q[s-1];
            end
        end
    end

    // Reset also masks the last stage so nothing escapes during the reset cycle.
    assign read_valid_o   = vld_q[READ_LATENCY] & ~reset_i;
    assign read_enables_o = read_valid_o ? en_q[READ_LATENCY] : '0;
    assign read_data_o    = read_valid_o ? dat_q[READ_LATENCY] : '0;

endmodule

// File: tb/tb_sm_banked_memory_pipelined.sv
// Directed + random bench for sm_banked_memory_pipelined with a load-return scoreboard.
module tb_sm_banked_memory_pipelined;
    localparam int BANKS = 16;
    localparam int ENTRIES = 16;
    localparam int AW = 4;
    localparam int BPE = 4;
    localparam int RL = 3;
    localparam int DW = 32;
`ifdef SM_INIT_ON_RESET_EN
    localparam int N_INIT = ENTRIES;
`else
    localparam int N_INIT = 1;
`endif

    logic clk = 0;
    logic rst = 1;
    logic req_valid = 0;
    logic req_ready;
    logic is_store = 0;
    logic [BANKS-1:0] enables = '0;
    logic [BANKS*AW-1:0] offs = '0;
    logic [BANKS*BPE-1:0] mask = '0;
    logic [BANKS*DW-1:0] wdata = '0;
    logic read_valid;
    logic [BANKS-1:0] read_en;
    logic [BANKS*DW-1:0] read_data;
    logic init_done;

    typedef struct {
        int                  due;
        logic [BANKS-1:0]    en;
        logic [BANKS*DW-1:0] data;
    } exp_t;

    exp_t q[$];
    logic [DW-1:0] model [BANKS][ENTRIES];
    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    bit mon_en = 0;

    sm_banked_memory_pipelined #(
        .BANKS(BANKS), .ENTRIES(ENTRIES), .ADDR_WIDTH(AW),
        .BYTES_PER_ENTRY(BPE), .READ_LATENCY(RL)
    ) dut (
        .clock_i(clk), .reset_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .is_store_i(is_store), .enables_i(enables), .bank_offsets_i(offs),
        .byte_mask_i(mask), .write_data_i(wdata), .read_valid_o(read_valid),
        .read_enables_o(read_en), .read_data_o(read_data), .init_done_o(init_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [BANKS*DW-1:0] got, input logic [BANKS*DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Monitor: compares each returned load against the scoreboard at its due cycle.
    always begin
        @(posedge clk);
        #2;
        if (mon_en) begin
            bit exp_v;
            exp_t e;
            exp_v = (q.size() > 0) && (q[0].due == edge_cnt);
            chk("read_valid", {{(BANKS*DW-1){1'b0}}, read_valid}, {{(BANKS*DW-1){1'b0}}, exp_v});
            if (exp_v) begin
                e = q.pop_front();
                chk("read_enables", {{(BANKS*DW-BANKS){1'b0}}, read_en}, {{(BANKS*DW-BANKS){1'b0}}, e.en});
                chk("read_data", read_data, e.data);
            end else begin
                chk("idle_data", read_data, '0);
            end
        end
    end

    function automatic logic [BANKS*AW-1:0] uoff(input int o);
        logic [AW-1:0] a;
        a = AW'(o);
        return {BANKS{a}};
    endfunction

    task automatic req(input logic st, input logic [BANKS-1:0] en, input logic [BANKS*AW-1:0] of,
                       input logic [BANKS*BPE-1:0] m, input logic [BANKS*DW-1:0] wd);
        exp_t e;
        req_valid = 1; is_store = st; enables = en; offs = of; mask = m; wdata = wd;
        if (st) begin
            for (int b = 0; b < BANKS; b++)
                if (en[b])
                    for (int k = 0; k < BPE; k++)
                        if (m[b*BPE+k]) model[b][of[b*AW +: AW]][k*8 +: 8] = wd[b*DW + k*8 +: 8];
        end else begin
            e.due = edge_cnt + RL;
            e.en = en;
            e.data = '0;
            for (int b = 0; b < BANKS; b++)
                if (en[b]) e.data[b*DW +: DW] = model[b][of[b*AW +: AW]];
            q.push_back(e);
        end
        @(negedge clk);
        req_valid = 0; is_store = 0;
    endtask

    task automatic store1(input int bank, input int off, input logic [DW-1:0] d, input logic [BPE-1:0] m);
        req(1'b1, BANKS'(1) << bank, uoff(off), (BANKS*BPE)'(m) << (bank*BPE), (BANKS*DW)'(d) << (bank*DW));
    endtask

    task automatic load(input logic [BANKS-1:0] en, input int off);
        req(1'b0, en, uoff(off), '0, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds reset n cycles, then checks the INIT window while offering a load that must be ignored.
    task automatic do_reset(input int n);
        rst = 1; req_valid = 0;
        q.delete();
        repeat (n) @(negedge clk);
        mon_en = 1;
        chk("rst_ready", {511'b0, req_ready}, '0);
        chk("rst_init_done", {511'b0, init_done}, '0);
`ifdef SM_INIT_ON_RESET_EN
        for (int b = 0; b < BANKS; b++)
            for (int a = 0; a < ENTRIES; a++) model[b][a] = '0;
`endif
        rst = 0;
        req_valid = 1; is_store = 0; enables = '1; offs = uoff(1);
        for (int i = 0; i < N_INIT; i++) begin
            chk("init_ready_low", {511'b0, req_ready}, '0);
            @(negedge clk);
        end
        req_valid = 0;
        chk("init_ready_high", {511'b0, req_ready}, 512'd1);
        chk("init_done_high", {511'b0, init_done}, 512'd1);
    endtask

    initial begin
        logic [BANKS*DW-1:0] rd;
        logic [BANKS*BPE-1:0] rm;
        logic [BANKS*AW-1:0] ro;
        @(negedge clk);
        do_reset(3);

`ifdef SM_INIT_ON_RESET_EN
        load('1, 5);
        idle(RL + 1);
`endif
        // Fill every entry so all later loads have defined expectations.
        for (int a = 0; a < ENTRIES; a++) begin
            for (int w = 0; w < BANKS; w++) rd[w*DW +: DW] = $urandom;
            req(1'b1, '1, uoff(a), '1, rd);
        end

        store1(3, 7, 32'hAABBCCDD, 4'b1111);
        store1(3, 7, 32'h11223344, 4'b0101);
        load(16'h0008, 7);
        idle(RL + 1);

        load('1, 10);
        load('1, 11);
        load('1, 12);
        idle(RL + 2);

        load(16'h0009, 4);
        idle(RL);

        store1(0, 2, 32'hDEADBEEF, 4'b1111);
        load('1, 2);
        idle(RL);

        load('0, 3);
        req(1'b1, '0, uoff(3), '1, '1);
        load('1, 3);
        idle(RL);

        for (int i = 0; i < 60; i++) begin
            for (int w = 0; w < BANKS; w++) rd[w*DW +: DW] = $urandom;
            rm = {$urandom, $urandom};
            ro = {$urandom, $urandom};
            req(1'($urandom_range(0, 1)), BANKS'($urandom), ro, rm, rd);
        end
        idle(RL + 1);

        load('1, 6);
        do_reset(2);
`ifdef SM_INIT_ON_RESET_EN
        load('1, 5);
`endif
        store1(5, 9, 32'h0BADF00D, 4'b1111);
        load(16'h0020, 9);
        idle(RL + 2);

        chk("queue_empty", 512'(q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sm_banked_memory_pipelined.md
Name: sm_banked_memory_pipelined

Overview:
- Parametrised next-generation scratchpad bank array: BANKS independent single-port byte-writable banks.
- Configurable depth, entry width and read latency; a valid-tracked read pipeline; ready/valid request acceptance; an optional zero-initialisation engine after reset.
- Sits between the scratchpad address-remapping/conflict stage and the output data-collection stage of the SPM pipeline.

Parameters:
- BANKS, 16, number of banks (power of two, 1..32)
- ENTRIES, 1024, entries per bank (power of two)
- ADDR_WIDTH, $clog2(ENTRIES), bank offset width
- BYTES_PER_ENTRY, 4, byte lanes per entry (byte = 8 bits)
- READ_LATENCY, 1, cycles from load acceptance to read_valid (legal 1..3)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request present this cycle
- req_ready  out  1  block can accept a request
- is_store  in  1  1 = store, 0 = load; applies to all banks
- enables  in  BANKS  per-bank participation mask
- bank_offsets  in  BANKS*ADDR_WIDTH  per-bank entry address
- byte_mask  in  BANKS*BYTES_PER_ENTRY  per-bank byte write mask (stores only)
- write_data  in  BANKS*BYTES_PER_ENTRY*8  per-bank store data
- read_valid  out  1  read_data valid for one accepted load
- read_enables  out  BANKS  enable mask of the load being returned
- read_data  out  BANKS*BYTES_PER_ENTRY*8  per-bank load data
- init_done  out  1  initialisation complete

Behaviour:
- Clocking: single clock domain on clock. Reset is synchronous and active-high.
- Reset values: req_ready=0, read_valid=0, read_enables=0, read_data=0, init_done=0. All pipeline valid bits are cleared. Memory contents are not reset by the reset itself.
- FSM states: INIT, READY.
  - reset -> INIT.
  - INIT -> READY when the init counter reaches ENTRIES-1 and that write completes.
  - READY holds until the next reset.
  - With SM_INIT_ON_RESET_EN undefined, INIT lasts exactly one cycle.
- INIT:
  - Counter starts at 0 and increments by 1 each cycle.
  - Each cycle writes all-zero data with a full byte mask to address=counter in every bank.
  - req_ready=0. Incoming requests are ignored and not queued.
- READY: req_ready=1 and init_done=1 every cycle. There is no back-pressure; the array accepts one request per cycle.
- Acceptance: a request is accepted when req_valid & req_ready.
- Accepted store: bank b writes byte lane k iff enables[b] & byte_mask[b][k]. Unselected lanes keep their contents. A store never produces read_valid.
- Accepted load: bank b reads bank_offsets[b] when enables[b]=1. byte_mask and write_data are ignored.
- Load return:
  - Exactly READ_LATENCY cycles after acceptance: read_valid=1 for one cycle, and read_enables carries the captured enables.
  - read_data lane b holds the bank data when the captured enables[b]=1, otherwise zero.
- Pipeline: stage 1 is the RAM output register. Stages 2..READ_LATENCY are data+enables+valid registers.
  - Back-to-back loads return back-to-back, in order.
  - When read_valid=0, read_data=0.
- Load after store, same bank and address, next cycle: the load returns the newly stored bytes (write-first ordering across cycles). A single request cannot both load and store.
- Reset mid-operation:
  - In-flight loads are discarded; read_valid stays 0 from the reset cycle on.
  - The FSM re-enters INIT and, with the feature enabled, zeroes the memory again from address 0.
- Request with enables=0: accepted and consumed. A load returns read_valid=1 with read_enables=0 and read_data=0.
- Width rules:
  - Flattened buses are bank-major: bank b occupies slice [b*W +: W].
  - The init counter is ADDR_WIDTH+1 bits wide so the terminal count is unambiguous.

Optional Feature:
- SM_INIT_ON_RESET_EN:
  - Defined: after every reset, INIT zeroes all ENTRIES addresses of all banks. init_done/req_ready rise on the cycle after the write to address ENTRIES-1, which is ENTRIES+1 cycles after reset deassertion.
  - Undefined: no zeroing; contents after reset are undefined. INIT lasts one cycle, and req_ready/init_done=1 from the 2nd cycle after reset deassertion.

Test Plan:
- Init: feature on, ENTRIES=16, reset 3 cycles then release -> req_ready=0 for 16 cycles, then 1; a load of all banks at offset 5 returns read_data=0 with read_valid=1.
- Byte mask: store 0xAABBCCDD to bank 3, offset 7, mask 4'b1111; then store 0x11223344 with mask 4'b0101; load -> bank 3 reads 0xAA22CC44.
- Latency: READ_LATENCY=3, loads accepted at cycles 10, 11, 12 with distinct data -> read_valid high at cycles 13, 14, 15, data in order; read_valid low at cycle 16.
- Partial enables: load with enables=16'h0009 -> read_enables=16'h0009, lanes 0 and 3 carry data, all other lanes 0.
- Store-then-load: store 0xDEADBEEF to bank 0, offset 2 at cycle t; load the same address at t+1 -> READ_LATENCY cycles later read_data[0]=0xDEADBEEF.
- Reset mid-flight: READ_LATENCY=2, load accepted at cycle t, reset asserted at t+1 -> read_valid never asserts; req_ready=0 until INIT completes again.
